// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: 32-entry register file, same-cycle
// writeback bypass, rs2/immediate select and a single-entry output register.
module alu_operand_stage #(
    parameter int XLEN          = 32,
    parameter int NREGS         = 32,
    parameter int ALU_OP_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ALU_OP_LENGTH-1:0] in_opcode,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [XLEN-1:0]          in_imm,
    input  logic                     in_use_imm,
    input  logic [4:0]               in_rd,
    input  logic                     in_rd_we,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ALU_OP_LENGTH-1:0] out_opcode,
    output logic [XLEN-1:0]          out_left,
    output logic [XLEN-1:0]          out_right,
    output logic [4:0]               out_rd,
    output logic                     out_rd_we,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data
);

    logic [XLEN-1:0]          regs_reg [NREGS];
    logic                     wb_active;
    logic                     bypass_rs1;
    logic                     bypass_rs2;
    logic [XLEN-1:0]          rs1_val;
    logic [XLEN-1:0]          rs2_val;
    logic [XLEN-1:0]          right_next;
    logic                     xfer;

    logic                     out_valid_reg;
    logic [ALU_OP_LENGTH-1:0] out_opcode_reg;
    logic [XLEN-1:0]          out_left_reg;
    logic [XLEN-1:0]          out_right_reg;
    logic [4:0]               out_rd_reg;
    logic                     out_rd_we_reg;

    // x0 is never written, so it stays at its reset value of zero.
    assign wb_active = wb_we && (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_active) begin
            regs_reg[wb_rd] <= wb_data;
        end
    end

    // A writeback landing this edge is visible to the instruction read alongside it.
    assign bypass_rs1 = wb_active && (wb_rd == in_rs1);
    assign bypass_rs2 = wb_active && (wb_rd == in_rs2);

    assign rs1_val    = (in_rs1 == 5'd0) ? '0 : (bypass_rs1 ? wb_data : regs_reg[in_rs1]);
    assign rs2_val    = (in_rs2 == 5'd0) ? '0 : (bypass_rs2 ? wb_data : regs_reg[in_rs2]);
    assign right_next = in_use_imm ? in_imm : rs2_val;

    assign in_ready = !out_valid_reg || out_ready;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg  <= 1'b0;
            out_opcode_reg <= '0;
            out_left_reg   <= '0;
            out_right_reg  <= '0;
            out_rd_reg     <= '0;
            out_rd_we_reg  <= 1'b0;
        end else if (xfer) begin
            out_valid_reg  <= 1'b1;
            out_opcode_reg <= in_opcode;
            out_left_reg   <= rs1_val;
            out_right_reg  <= right_next;
            out_rd_reg     <= in_rd;
            out_rd_we_reg  <= in_rd_we;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_opcode = out_opcode_reg;
    assign out_left   = out_left_reg;
    assign out_right  = out_right_reg;
    assign out_rd     = out_rd_reg;
    assign out_rd_we  = out_rd_we_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, hand-written
// backpressure/reset sequences and randomized traffic against a reference model.
module tb_alu_operand_stage;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [31:0] out_left;
    logic [31:0] out_right;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    alu_operand_stage #(.XLEN(32), .NREGS(32), .ALU_OP_LENGTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_rd      (in_rd),
        .in_rd_we   (in_rd_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_left   (out_left),
        .out_right  (out_right),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nmis = 0;

    // Reference model: architectural register contents plus the one pending ALU slot.
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [3:0]  m_op;
    logic [31:0] m_left;
    logic [31:0] m_right;
    logic [4:0]  m_rd;
    logic        m_rd_we;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        iv;
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic [31:0] exp_left;
        logic [31:0] exp_right;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0; m_op = '0; m_left = '0; m_right = '0; m_rd = '0; m_rd_we = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic model_check();
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_opcode", {28'd0, out_opcode}, {28'd0, m_op});
        chk("out_left", out_left, m_left);
        chk("out_right", out_right, m_right);
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, m_rd_we});
    endtask

    task automatic model_edge();
        logic ready;
        ready = !m_valid || out_ready;
        if (in_valid && ready) begin
            m_valid = 1'b1;
            m_op    = in_opcode;
            m_left  = model_read(in_rs1);
            m_right = in_use_imm ? in_imm : model_read(in_rs2);
            m_rd    = in_rd;
            m_rd_we = in_rd_we;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    endtask

    // Inputs are driven just after a rising edge; outputs checked on the falling edge.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic iv, input logic [3:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm,
                         input logic [4:0] rd, input logic rd_we);
        in_valid = iv; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_use_imm = use_imm; in_rd = rd; in_rd_we = rd_we;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_we = we; wb_rd = rd; wb_data = data;
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'h4,        1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,  32'd0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b1, OP_ADD, 5'd5, 5'd0, 32'd3, 1'b1, 5'd6, 32'h4,  32'h3};
        tbl[2] = '{1'b1, 5'd7, 32'hC,        1'b1, OP_ADD, 5'd7, 5'd7, 32'd0, 1'b0, 5'd8, 32'hC,  32'hC};
        tbl[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,  32'd0};
        tbl[4] = '{1'b1, 5'd1, 32'hC,        1'b1, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd9, 32'd0,  32'd0};
        tbl[5] = '{1'b1, 5'd2, 32'hA,        1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,  32'd0};
        tbl[6] = '{1'b1, 5'd3, 32'h7,        1'b1, OP_AND, 5'd1, 5'd2, 32'd0, 1'b0, 5'd4, 32'hC,  32'hA};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, OP_SUB, 5'd3, 5'd0, 32'd3, 1'b1, 5'd4, 32'h7,  32'h3};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b1, OP_ADD, 5'd5, 5'd0, 32'd3, 1'b1, 5'd4, 32'h4,  32'h3};

        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'd0);
        model_reset();
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_left", out_left, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed table: write/read, bypass, x0 discard, back-to-back AND/SUB/ADD.
        for (int i = 0; i < 9; i++) begin
            drive_wb(tbl[i].wb_we, tbl[i].wb_rd, tbl[i].wb_data);
            drive(tbl[i].iv, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                  tbl[i].use_imm, tbl[i].rd, 1'b1);
            step();
            chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].iv});
            if (tbl[i].iv) begin
                chk($sformatf("tbl%0d_left", i), out_left, tbl[i].exp_left);
                chk($sformatf("tbl%0d_right", i), out_right, tbl[i].exp_right);
                chk($sformatf("tbl%0d_op", i), {28'd0, out_opcode}, {28'd0, tbl[i].op});
            end
        end
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'd0);
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: A held for 3 stalled cycles while B waits, with a writeback to A's source.
        drive(1'b1, OP_SUB, 5'd5, 5'd0, 32'h55, 1'b1, 5'd9, 1'b1);
        step();
        chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        drive(1'b1, OP_AND, 5'd7, 5'd0, 32'h66, 1'b1, 5'd10, 1'b1);
        drive_wb(1'b1, 5'd5, 32'h99);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_left", out_left, 32'h4);
            chk("bp_hold_right", out_right, 32'h55);
            chk("bp_hold_rd", {27'd0, out_rd}, 32'd9);
        end
        drive_wb(1'b0, 5'd0, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_b_left", out_left, 32'hC);
        chk("bp_b_right", out_right, 32'h66);
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        step();
        chk("bp_no_dup", {31'd0, out_valid}, 32'd0);
        chk("x5_after_stall_wb", m_regs[5], 32'h99);

        // Randomized traffic; narrow register range makes bypass hits frequent.
        for (int n = 0; n < 600; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            drive_wb($urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
            step();
        end

        // Mid-stream asynchronous reset with an instruction held in the output register.
        out_ready = 1'b1;
        drive_wb(1'b0, 5'd0, 32'd0);
        drive(1'b1, OP_SUB, 5'd7, 5'd3, 32'h0, 1'b0, 5'd11, 1'b1);
        step();
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_op", {28'd0, out_opcode}, 32'd0);
        chk("async_rst_left", out_left, 32'd0);
        chk("async_rst_right", out_right, 32'd0);
        chk("async_rst_rd", {27'd0, out_rd}, 32'd0);
        chk("async_rst_rd_we", {31'd0, out_rd_we}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, OP_ADD, 5'(r), 5'(32 - r), 32'd0, 1'b0, 5'd0, 1'b0);
            step();
            chk($sformatf("rst_x%0d_left", r), out_left, 32'd0);
            chk($sformatf("rst_x%0d_right", r), out_right, 32'd0);
        end
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the ALU; owns the 32-entry integer register file.
- Accepts a decoded instruction over a valid/ready handshake and reads rs1/rs2.
- Selects rs2 or the immediate as the right operand and registers opcode/left/right for the ALU.
- Takes the ALU result back through a writeback port, closing the execute loop.

Parameters:
XLEN, 32, datapath width; the ALU is fixed at 32, so only 32 is supported.
NREGS, 32, number of architectural registers; register address width is 5.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous reset, active-low.
in_valid  input  1  decoded instruction present.
in_ready  output  1  stage can accept an instruction this cycle.
in_opcode  input  ALU_OP_LENGTH  ALU operation, encoding from the shared parameters header.
in_rs1  input  5  left source register.
in_rs2  input  5  right source register.
in_imm  input  32  sign-extended immediate.
in_use_imm  input  1  1: right operand = in_imm; 0: right operand = rs2 value.
in_rd  input  5  destination register.
in_rd_we  input  1  instruction writes rd.
out_valid  output  1  operands valid for the ALU.
out_ready  input  1  ALU/downstream accepts this cycle.
out_opcode  output  ALU_OP_LENGTH  registered opcode.
out_left  output  32  registered left operand.
out_right  output  32  registered right operand.
out_rd  output  5  registered destination.
out_rd_we  output  1  registered write enable.
wb_we  input  1  writeback strobe.
wb_rd  input  5  writeback register.
wb_data  input  32  writeback value (ALU result).

Behaviour:
- Reset (reset_n low, asynchronous):
  - All 32 registers go to 0.
  - out_valid=0; out_opcode, out_left, out_right, out_rd, out_rd_we all 0.
  - Applies immediately without a clock edge, including mid-transfer. Any in-flight instruction is dropped.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - On a rising edge with wb_we=1 and wb_rd!=0, reg[wb_rd] <= wb_data.
  - Writes to x0 are discarded; x0 always reads 0.
- Write-before-read bypass: if wb_we=1, wb_rd!=0 and wb_rd equals the rs1 (or rs2) being read in the same cycle, that operand uses wb_data, not the stale array value.
  - Applies independently to each port.
  - rs1==rs2==wb_rd gives wb_data on both.
- Operand select:
  - left = rs1 value.
  - right = in_use_imm ? in_imm : rs2 value.
  - No width conversion; all 32 bits pass through.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single-entry pipeline register, no skid).
  - A transfer occurs when in_valid && in_ready at a rising edge. The output register loads opcode/left/right/rd/rd_we and sets out_valid=1.
  - Latency: 1 cycle from accepted input to out_valid.
  - If out_valid && out_ready and no new transfer, out_valid <= 0.
  - Simultaneous drain and fill (out_valid && out_ready && in_valid): the register reloads and out_valid stays 1. Full throughput is one instruction per cycle.
  - While out_valid && !out_ready, all out_* are held stable, in_ready=0, and inputs are ignored.
  - Writebacks still update the register file during a stall. Held operands are not refreshed.
- No hazard detection against in-flight rd: the issuer is responsible for stalling dependent instructions. The bypass covers only the same-cycle writeback.
- in_* values are don't-care when in_valid=0. The output register is not loaded without a transfer.

Test Plan:
- Reset: assert reset_n=0 mid-stream with out_valid=1 -> out_valid=0 and all out_* 0 immediately; afterwards, reading x1..x31 returns 0.
- Write/read: wb writes x5=32'h4, next cycle issue rs1=5, rs2=0, use_imm=1, imm=3, opcode=ALU_OP_ADD -> one cycle later out_valid=1, out_left=4, out_right=3, out_opcode=ALU_OP_ADD.
- Bypass: same cycle as wb x7=32'hC, issue rs1=7, rs2=7, use_imm=0 -> out_left=out_right=32'hC.
- x0: wb_we=1, wb_rd=0, wb_data=32'hFFFFFFFF, then read rs1=0 -> out_left=0.
- Backpressure: out_ready=0 with out_valid=1 and a second instruction offered -> in_ready=0 and outputs unchanged for 3 cycles. Then out_ready=1 -> the second instruction appears the next cycle, and no instruction is lost or duplicated.
- Back-to-back: out_ready=1, three consecutive instructions (AND 32'b1100/32'b1010, SUB 7/3, ADD 4/3) -> out_valid high 3 consecutive cycles, operands in order.
